// File: rtl/cascade_ctrl_pkg.sv
// Shared types and default sizing for the cascade stage controller.
// Optional per-window stage statistics: define CASCADE_STAGE_STATS_EN.
package cascade_ctrl_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NUM_WIN    = 4;
  localparam int DEF_MAX_STAGES = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_THR,
    S_WAIT_SUM,
    S_CMP,
    S_FINISH
  } state_t;

endpackage

// File: rtl/stage_compare.sv
// Per-window signed stage-sum versus threshold compare.
// Pure combinational; one instance per detection window.
module stage_compare #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] sum_i,
  input  logic [DATA_W-1:0] thr_i,
  output logic              pass_o
);

  assign pass_o = $signed(sum_i) >= $signed(thr_i);

endmodule

// File: rtl/cascade_stage_ctrl.sv
// Cascade evaluation controller: sequences stages, tracks live windows.
// Define CASCADE_STAGE_STATS_EN to add per-window passed-stage counters.
module cascade_stage_ctrl
  import cascade_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_WIN    = DEF_NUM_WIN,
  parameter int MAX_STAGES = DEF_MAX_STAGES,
  localparam int SW = (MAX_STAGES > 1) ? $clog2(MAX_STAGES) : 1,
  localparam int CW = $clog2(MAX_STAGES + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [CW-1:0]             num_stages_i,
  input  logic [DATA_W-1:0]         thr_i,
  input  logic                      thr_val_i,
  input  logic [NUM_WIN*DATA_W-1:0] sum_i,
  input  logic                      sum_val_i,
  output logic                      busy_o,
  output logic [SW-1:0]             stage_idx_o,
  output logic                      next_stage_o,
  output logic                      break_o,
  output logic                      done_o,
  output logic [NUM_WIN-1:0]        alive_o,
`ifdef CASCADE_STAGE_STATS_EN
  output logic [NUM_WIN*CW-1:0]     stats_o,
`endif
  output logic [NUM_WIN-1:0]        result_o
);

  state_t                    state_q;
  logic [CW-1:0]             nstg_q;
  logic [CW-1:0]             nstg_in;
  logic [DATA_W-1:0]         thr_q;
  logic [NUM_WIN*DATA_W-1:0] sum_q;
  logic [NUM_WIN-1:0]        pass;
  logic [NUM_WIN-1:0]        alive_nxt;
  logic                      last;

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_cmp
    stage_compare #(
      .DATA_W(DATA_W)
    ) u_cmp (
      .sum_i (sum_q[g*DATA_W +: DATA_W]),
      .thr_i (thr_q),
      .pass_o(pass[g])
    );
  end

  // Depth 0 runs one stage; oversize requests saturate at MAX_STAGES.
  always_comb begin
    nstg_in = num_stages_i;
    if (num_stages_i == '0)
      nstg_in = CW'(1);
    else if (num_stages_i > CW'(MAX_STAGES))
      nstg_in = CW'(MAX_STAGES);
  end

  assign alive_nxt = alive_o & pass;
  assign last = CW'(stage_idx_o) == (nstg_q - CW'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      nstg_q       <= CW'(1);
      thr_q        <= '0;
      sum_q        <= '0;
      busy_o       <= 1'b0;
      stage_idx_o  <= '0;
      next_stage_o <= 1'b0;
      break_o      <= 1'b1;
      done_o       <= 1'b0;
      alive_o      <= '0;
      result_o     <= '0;
    end else begin
      next_stage_o <= 1'b0;
      done_o       <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            nstg_q      <= nstg_in;
            stage_idx_o <= '0;
            alive_o     <= '1;
            result_o    <= '0;
            busy_o      <= 1'b1;
            break_o     <= 1'b0;
            state_q     <= S_WAIT_THR;
          end
        end
        S_WAIT_THR: begin
          if (thr_val_i) begin
            thr_q <= thr_i;
            if (sum_val_i) begin
              sum_q   <= sum_i;
              state_q <= S_CMP;
            end else begin
              state_q <= S_WAIT_SUM;
            end
          end
        end
        S_WAIT_SUM: begin
          if (sum_val_i) begin
            sum_q   <= sum_i;
            state_q <= S_CMP;
          end
        end
        S_CMP: begin
          alive_o <= alive_nxt;
          if (alive_nxt == '0 || last) begin
            result_o <= alive_nxt;
            done_o   <= 1'b1;
            break_o  <= 1'b1;
            state_q  <= S_FINISH;
          end else begin
            next_stage_o <= 1'b1;
            stage_idx_o  <= stage_idx_o + 1'b1;
            state_q      <= S_WAIT_THR;
          end
        end
        S_FINISH: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          break_o <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CASCADE_STAGE_STATS_EN
  // Only windows still alive can credit a pass.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stats_o <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      stats_o <= '0;
    end else if (state_q == S_CMP) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (alive_o[i] && pass[i])
          stats_o[i*CW +: CW] <= stats_o[i*CW +: CW] + CW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cascade_stage_ctrl.sv
// Directed self-checking bench for cascade_stage_ctrl.
// Stats checks are compiled in with CASCADE_STAGE_STATS_EN.
module tb_cascade_stage_ctrl;

  localparam int DW = 32;
  localparam int NW = 4;
  localparam int MS = 4;
  localparam int SW = 2;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [CW-1:0]    num_stages_i;
  logic [DW-1:0]    thr_i;
  logic             thr_val_i;
  logic [NW*DW-1:0] sum_i;
  logic             sum_val_i;
  logic             busy_o;
  logic [SW-1:0]    stage_idx_o;
  logic             next_stage_o;
  logic             break_o;
  logic             done_o;
  logic [NW-1:0]    alive_o;
  logic [NW-1:0]    result_o;
`ifdef CASCADE_STAGE_STATS_EN
  logic [NW*CW-1:0] stats_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cascade_stage_ctrl #(
    .DATA_W(DW),
    .NUM_WIN(NW),
    .MAX_STAGES(MS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .num_stages_i(num_stages_i),
    .thr_i       (thr_i),
    .thr_val_i   (thr_val_i),
    .sum_i       (sum_i),
    .sum_val_i   (sum_val_i),
    .busy_o      (busy_o),
    .stage_idx_o (stage_idx_o),
    .next_stage_o(next_stage_o),
    .break_o     (break_o),
    .done_o      (done_o),
    .alive_o     (alive_o),
`ifdef CASCADE_STAGE_STATS_EN
    .stats_o     (stats_o),
`endif
    .result_o    (result_o)
  );

  function automatic logic [NW*DW-1:0] pk(int w0, int w1, int w2, int w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    start_i = 1'b1;
    num_stages_i = n;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_both(input int thr, input logic [NW*DW-1:0] s);
    thr_i = thr;
    sum_i = s;
    thr_val_i = 1'b1;
    sum_val_i = 1'b1;
    tick();
    thr_val_i = 1'b0;
    sum_val_i = 1'b0;
  endtask

  task automatic send_thr(input int thr);
    thr_i = thr;
    thr_val_i = 1'b1;
    tick();
    thr_val_i = 1'b0;
  endtask

  task automatic send_sum(input logic [NW*DW-1:0] s);
    sum_i = s;
    sum_val_i = 1'b1;
    tick();
    sum_val_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || next_stage_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_ctl got busy=%b done=%b next=%b exp 0/0/0",
               busy_o, done_o, next_stage_o);
    end
    checks++;
    if (break_o !== 1'b1 || stage_idx_o !== 2'd0) begin
      failures++;
      $display("FAIL rst_brk got break=%b idx=%0d exp 1/0", break_o, stage_idx_o);
    end
    checks++;
    if (alive_o !== 4'b0000 || result_o !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mask got alive=%b res=%b exp 0000/0000", alive_o, result_o);
    end
    rst_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0 || break_o !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_rst got busy=%b break=%b exp 0/1", busy_o, break_o);
    end
  endtask

  task automatic test_all_pass();
    int np = 0;
    do_start(3'd3);
    checks++;
    if (busy_o !== 1'b1 || alive_o !== 4'b1111 || break_o !== 1'b0) begin
      failures++;
      $display("FAIL start_state got busy=%b alive=%b break=%b exp 1/1111/0",
               busy_o, alive_o, break_o);
    end
    for (int s = 0; s < 3; s++) begin
      send_both(100, pk(150, 150, 150, 150));
      checks++;
      if (done_o !== 1'b0 || next_stage_o !== 1'b0) begin
        failures++;
        $display("FAIL cmp_quiet s%0d got done=%b next=%b exp 0/0", s, done_o, next_stage_o);
      end
      tick();
      if (next_stage_o === 1'b1) np++;
      if (s < 2) begin
        checks++;
        if (next_stage_o !== 1'b1 || stage_idx_o !== SW'(s + 1) || done_o !== 1'b0) begin
          failures++;
          $display("FAIL adv s%0d got next=%b idx=%0d done=%b exp 1/%0d/0",
                   s, next_stage_o, stage_idx_o, done_o, s + 1);
        end
      end else begin
        checks++;
        if (done_o !== 1'b1 || result_o !== 4'b1111 || stage_idx_o !== 2'd2) begin
          failures++;
          $display("FAIL pass_done got done=%b res=%b idx=%0d exp 1/1111/2",
                   done_o, result_o, stage_idx_o);
        end
      end
    end
    checks++;
    if (np != 2) begin
      failures++;
      $display("FAIL pass_pulses got %0d exp 2", np);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 4'b1111) begin
      failures++;
      $display("FAIL pass_idle got done=%b busy=%b res=%b exp 0/0/1111",
               done_o, busy_o, result_o);
    end
  endtask

  task automatic test_partial();
    do_start(3'd3);
    send_thr(100);
    send_sum(pk(50, 200, 200, 200));
    tick();
    checks++;
    if (alive_o !== 4'b1110 || next_stage_o !== 1'b1) begin
      failures++;
      $display("FAIL part_s0 got alive=%b next=%b exp 1110/1", alive_o, next_stage_o);
    end
    send_thr(100);
    send_sum(pk(300, 50, 300, 300));
    tick();
    checks++;
    if (alive_o !== 4'b1100) begin
      failures++;
      $display("FAIL part_s1 got alive=%b exp 1100", alive_o);
    end
    send_thr(100);
    send_sum(pk(300, 300, 300, 300));
    tick();
    checks++;
    if (done_o !== 1'b1 || result_o !== 4'b1100) begin
      failures++;
      $display("FAIL part_done got done=%b res=%b exp 1/1100", done_o, result_o);
    end
`ifdef CASCADE_STAGE_STATS_EN
    checks++;
    if (stats_o !== {3'd3, 3'd3, 3'd1, 3'd0}) begin
      failures++;
      $display("FAIL stats got %h exp %h", stats_o, {3'd3, 3'd3, 3'd1, 3'd0});
    end
`endif
    tick();
  endtask

  task automatic test_early_reject();
    do_start(3'd3);
    send_both(100, pk(99, 99, 99, 99));
    checks++;
    if (done_o !== 1'b0) begin
      failures++;
      $display("FAIL rej_early got done=%b exp 0", done_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b1 || next_stage_o !== 1'b0 || result_o !== 4'b0000 ||
        alive_o !== 4'b0000) begin
      failures++;
      $display("FAIL rej_done got done=%b next=%b res=%b alive=%b exp 1/0/0000/0000",
               done_o, next_stage_o, result_o, alive_o);
    end
    tick();
    checks++;
    if (break_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL rej_idle got break=%b done=%b busy=%b exp 1/0/0",
               break_o, done_o, busy_o);
    end
  endtask

  task automatic test_ignore();
    send_both(7, pk(1, 1, 1, 1));
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_strobes got busy=%b exp 0", busy_o);
    end
    do_start(3'd1);
    for (int k = 0; k < 3; k++) send_sum(pk(-100, -100, -100, -100));
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL early_sum got busy=%b done=%b exp 1/0", busy_o, done_o);
    end
    send_thr(-5);
    send_thr(1000);
    send_sum(pk(-5, -5, -5, -5));
    tick();
    checks++;
    if (done_o !== 1'b1 || result_o !== 4'b1111) begin
      failures++;
      $display("FAIL neg_eq got done=%b res=%b exp 1/1111", done_o, result_o);
    end
    tick();
  endtask

  task automatic test_signed();
    do_start(3'd1);
    send_both(-5, pk(-6, -5, 0, 7));
    tick();
    checks++;
    if (done_o !== 1'b1 || result_o !== 4'b1110) begin
      failures++;
      $display("FAIL signed got done=%b res=%b exp 1/1110", done_o, result_o);
    end
    tick();
  endtask

  task automatic test_clamp();
    int np = 0;
    logic seen = 1'b0;
    do_start(3'd0);
    send_both(100, pk(150, 150, 150, 150));
    tick();
    checks++;
    if (done_o !== 1'b1 || next_stage_o !== 1'b0) begin
      failures++;
      $display("FAIL zero_depth got done=%b next=%b exp 1/0", done_o, next_stage_o);
    end
    tick();
    do_start(3'd7);
    for (int s = 0; s < 4; s++) begin
      send_both(100, pk(150, 150, 150, 150));
      tick();
      if (next_stage_o === 1'b1) np++;
      if (done_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (np != 3 || seen !== 1'b1 || stage_idx_o !== 2'd3) begin
      failures++;
      $display("FAIL clamp got pulses=%0d done=%b idx=%0d exp 3/1/3",
               np, seen, stage_idx_o);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    do_start(3'd2);
    start_i = 1'b1;
    num_stages_i = 3'd1;
    tick();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || stage_idx_o !== 2'd0) begin
      failures++;
      $display("FAIL busy_start got busy=%b idx=%0d exp 1/0", busy_o, stage_idx_o);
    end
    send_both(100, pk(150, 150, 150, 150));
    tick();
    checks++;
    if (next_stage_o !== 1'b1 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL busy_relatch got next=%b done=%b exp 1/0", next_stage_o, done_o);
    end
    send_both(100, pk(150, 150, 150, 150));
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL finish_start got busy=%b exp 0", busy_o);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || break_o !== 1'b1) begin
      failures++;
      $display("FAIL finish_start2 got busy=%b break=%b exp 0/1", busy_o, break_o);
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    do_start(3'd3);
    send_both(100, pk(150, 150, 150, 150));
    tick();
    send_thr(100);
    rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || stage_idx_o !== 2'd0 || break_o !== 1'b1 ||
        alive_o !== 4'b0000 || result_o !== 4'b0000 || done_o !== 1'b0 ||
        next_stage_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got busy=%b idx=%0d brk=%b alive=%b res=%b done=%b next=%b",
               busy_o, stage_idx_o, break_o, alive_o, result_o, done_o, next_stage_o);
    end
    tick();
    rst_i = 1'b0;
    sum_i = pk(150, 150, 150, 150);
    sum_val_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      sum_val_i = 1'b0;
      if (done_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_quiet got done_seen=%b busy=%b exp 0/0", seen, busy_o);
    end
    do_start(3'd1);
    send_both(100, pk(150, 150, 150, 150));
    tick();
    checks++;
    if (done_o !== 1'b1 || result_o !== 4'b1111) begin
      failures++;
      $display("FAIL mid_rst_rerun got done=%b res=%b exp 1/1111", done_o, result_o);
    end
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    num_stages_i = '0;
    thr_i = '0;
    thr_val_i = 1'b0;
    sum_i = '0;
    sum_val_i = 1'b0;
    test_reset();
    test_all_pass();
    test_partial();
    test_early_reject();
    test_ignore();
    test_signed();
    test_clamp();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
